// File: rtl/clock_pkg.sv
// Shared constants for the 12-hour clock chain: mode encodings and BCD digit limits.
package clock_pkg;

    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_SET_MIN = 2'd1;
    localparam logic [1:0] MODE_SET_HR  = 2'd2;

    localparam logic [3:0] BCD_MAX_TENS = 4'd5;
    localparam logic [3:0] BCD_MAX_ONES = 4'd9;

endpackage

// File: rtl/bcd_counter_00_59.sv
// Two-digit BCD counter 00..59 with enable, synchronous clear and a combinational wrap carry.
module bcd_counter_00_59
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    logic at_max_ones;
    logic at_max_tens;

    assign at_max_ones = (ones == BCD_MAX_ONES);
    assign at_max_tens = (tens == BCD_MAX_TENS);
    assign carry       = en && at_max_tens && at_max_ones;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= '0;
            ones <= '0;
        end else if (clr) begin
            tens <= '0;
            ones <= '0;
        end else if (en) begin
            if (at_max_ones) begin
                ones <= '0;
                tens <= at_max_tens ? 4'd0 : tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/clock_min_sec_timebase.sv
// 1 Hz prescaler, BCD seconds/minutes and the RUN/SET_MIN/SET_HR time-set FSM.
// Optional field blink outputs are enabled by defining CLOCK_BLINK_EN.
module clock_min_sec_timebase
    import clock_pkg::*;
#(
    parameter int DIV = 50_000_000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [1:0] mode,
    output logic       tick,
    output logic       hour_inc,
    output logic       min_blank,
    output logic       hr_blank
);

    localparam int PW = $clog2(DIV);

    logic [PW-1:0] presc;
    logic [1:0]    mode_q;
    logic [1:0]    mode_d;
    logic          presc_last;
    logic          exit_set;
    logic          set_min_inc;
    logic          set_hr_inc;
    logic          sec_carry;
    logic          min_carry;
    logic          min_en;

    assign presc_last  = (presc == PW'(DIV - 1));
    assign tick        = en && (mode_q == MODE_RUN) && presc_last;
    assign exit_set    = (mode_q == MODE_SET_HR) && btn_mode;
    assign set_min_inc = (mode_q == MODE_SET_MIN) && btn_inc && !btn_mode;
    assign set_hr_inc  = (mode_q == MODE_SET_HR) && btn_inc && !btn_mode;
    assign min_en      = sec_carry || set_min_inc;
    // A minute wrap from a SET_MIN increment must not roll the hours.
    assign hour_inc    = (min_carry && (mode_q == MODE_RUN)) || set_hr_inc;
    assign mode        = mode_q;

    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_RUN:     if (btn_mode) mode_d = MODE_SET_MIN;
            MODE_SET_MIN: if (btn_mode) mode_d = MODE_SET_HR;
            MODE_SET_HR:  if (btn_mode) mode_d = MODE_RUN;
            default:      mode_d = MODE_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_RUN;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Leaving SET_HR restarts the second so the first tick is a full period away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (exit_set) begin
            presc <= '0;
        end else if (en) begin
            presc <= presc_last ? '0 : presc + 1'b1;
        end
    end

    bcd_counter_00_59 u_sec (
        .clk   (clk),
        .rst   (rst),
        .en    (tick),
        .clr   (exit_set),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .carry (sec_carry)
    );

    bcd_counter_00_59 u_min (
        .clk   (clk),
        .rst   (rst),
        .en    (min_en),
        .clr   (1'b0),
        .tens  (min_tens),
        .ones  (min_ones),
        .carry (min_carry)
    );

`ifdef CLOCK_BLINK_EN
    logic presc_hi;
    assign presc_hi  = (presc >= PW'(DIV / 2));
    assign min_blank = (mode_q == MODE_SET_MIN) && presc_hi;
    assign hr_blank  = (mode_q == MODE_SET_HR) && presc_hi;
`else
    assign min_blank = 1'b0;
    assign hr_blank  = 1'b0;
`endif

endmodule

// File: tb/tb_clock_min_sec_timebase.sv
// Scoreboard bench for clock_min_sec_timebase with DIV=4; stimulus queues expectations, a negedge monitor checks them.
module tb_clock_min_sec_timebase;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] sec_tens, sec_ones, min_tens, min_ones;
    logic [1:0] mode;
    logic       tick, hour_inc, min_blank, hr_blank;

    clock_min_sec_timebase #(.DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .mode      (mode),
        .tick      (tick),
        .hour_inc  (hour_inc),
        .min_blank (min_blank),
        .hr_blank  (hr_blank)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum {F_SEC, F_MIN, F_MODE, F_TICK, F_HINC, F_MBL, F_HBL} fld_t;
    typedef struct {
        int unsigned cyc;
        fld_t        f;
        logic [7:0]  v;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;

    task automatic want(input fld_t f, input logic [7:0] v, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.f    = f;
        e.v    = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] actual(input fld_t f);
        case (f)
            F_SEC:   return {sec_tens, sec_ones};
            F_MIN:   return {min_tens, min_ones};
            F_MODE:  return {6'd0, mode};
            F_TICK:  return {7'd0, tick};
            F_HINC:  return {7'd0, hour_inc};
            F_MBL:   return {7'd0, min_blank};
            default: return {7'd0, hr_blank};
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            compared++;
            if (e.cyc != cyc) begin
                mismatched++;
                $display("FAIL %s: stale, checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else if (actual(e.f) !== e.v) begin
                mismatched++;
                $display("FAIL %s: got %h, required %h (cycle %0d)", e.name, actual(e.f), e.v, cyc);
            end
        end
    end

    function automatic logic blink_exp(input int unsigned p);
`ifdef CLOCK_BLINK_EN
        return (p >= 2);
`else
        return (p > 99);
`endif
    endfunction

    initial begin
        logic [7:0] set_min_seq [3];
        exp_t       left;
        set_min_seq[0] = 8'h59;
        set_min_seq[1] = 8'h00;
        set_min_seq[2] = 8'h01;

        step(2);
        want(F_SEC, 8'h00, "rst_sec");
        want(F_MIN, 8'h00, "rst_min");
        want(F_MODE, 8'd0, "rst_mode");
        want(F_TICK, 8'd0, "rst_tick");
        want(F_HINC, 8'd0, "rst_hinc");
        want(F_MBL, 8'd0, "rst_min_blank");
        want(F_HBL, 8'd0, "rst_hr_blank");
        rst = 1'b0;
        en  = 1'b1;

        // ticks in the 4th, 8th and 12th cycle after release
        for (int k = 1; k <= 12; k++) begin
            step(1);
            want(F_TICK, {7'd0, (k % 4 == 3)}, $sformatf("tick_c%0d", k));
            want(F_HINC, 8'd0, "hinc_run");
        end
        want(F_SEC, 8'h03, "sec_after_12");
        want(F_MIN, 8'h00, "min_after_12");

        btn_mode = 1'b1; step(1); btn_mode = 1'b0;
        want(F_MODE, 8'd1, "mode_set_min");
        btn_inc = 1'b1; step(58); btn_inc = 1'b0;
        want(F_MIN, 8'h58, "set_min_58");
        for (int i = 0; i < 3; i++) begin
            btn_inc = 1'b1;
            want(F_HINC, 8'd0, "set_min_no_hinc");
            want(F_TICK, 8'd0, "set_min_no_tick");
            step(1);
            btn_inc = 1'b0;
            want(F_MIN, set_min_seq[i], $sformatf("set_min_inc%0d", i));
            want(F_SEC, 8'h03, "set_min_sec_frozen");
        end
        btn_inc = 1'b1; step(58); btn_inc = 1'b0;
        want(F_MIN, 8'h59, "set_min_59");

        btn_mode = 1'b1; step(1);
        want(F_MODE, 8'd2, "mode_set_hr");
        want(F_HINC, 8'd0, "set_hr_mode_only");
        step(1); btn_mode = 1'b0;
        want(F_MODE, 8'd0, "mode_run_a");
        want(F_SEC, 8'h00, "exit_clears_sec_a");

        step(232);
        want(F_SEC, 8'h58, "sec_58");
        want(F_MIN, 8'h59, "min_59");
        for (int j = 1; j <= 8; j++) begin
            step(1);
            want(F_HINC, {7'd0, (j == 7)}, $sformatf("wrap_hinc_%0d", j));
            want(F_TICK, {7'd0, (j == 3 || j == 7)}, $sformatf("wrap_tick_%0d", j));
            if (j == 4) want(F_SEC, 8'h59, "sec_59");
        end
        want(F_SEC, 8'h00, "wrap_sec_00");
        want(F_MIN, 8'h00, "wrap_min_00");

        step(8);
        want(F_SEC, 8'h02, "sec_02");
        btn_mode = 1'b1; step(1);
        want(F_MODE, 8'd1, "to_set_min_b");
        step(1); btn_mode = 1'b0; btn_inc = 1'b1;
        want(F_MODE, 8'd2, "to_set_hr_b");
        want(F_HINC, 8'd1, "set_hr_hinc");
        want(F_TICK, 8'd0, "set_hr_tick0");
        step(1); btn_inc = 1'b0;
        want(F_HINC, 8'd0, "set_hr_hinc_once");
        want(F_TICK, 8'd0, "set_hr_tick_presc3");
        want(F_SEC, 8'h02, "set_hr_sec_frozen");
        want(F_MIN, 8'h00, "set_hr_min_frozen");
        btn_mode = 1'b1; btn_inc = 1'b1;
        want(F_HINC, 8'd0, "set_hr_both_no_hinc");
        step(1); btn_mode = 1'b0; btn_inc = 1'b0;
        want(F_MODE, 8'd0, "mode_run_b");
        want(F_SEC, 8'h00, "exit_clears_sec_b");
        for (int t = 0; t < 4; t++) begin
            want(F_TICK, {7'd0, (t == 3)}, $sformatf("exit_tick_%0d", t));
            step(1);
        end
        want(F_SEC, 8'h01, "sec_after_exit_tick");

        btn_mode = 1'b1; step(1); btn_mode = 1'b0;
        want(F_MODE, 8'd1, "to_set_min_c");
        btn_mode = 1'b1; btn_inc = 1'b1;
        want(F_HINC, 8'd0, "set_min_both_no_hinc");
        step(1); btn_mode = 1'b0; btn_inc = 1'b0;
        want(F_MODE, 8'd2, "both_mode_wins");
        want(F_MIN, 8'h00, "both_min_unchanged");
        want(F_SEC, 8'h01, "both_sec_unchanged");
        btn_mode = 1'b1; step(1); btn_mode = 1'b0;
        want(F_MODE, 8'd0, "mode_run_c");
        want(F_SEC, 8'h00, "exit_clears_sec_c");

        step(2);
        en = 1'b0;
        for (int t = 0; t < 10; t++) begin
            want(F_TICK, 8'd0, "en0_tick");
            step(1);
        end
        want(F_SEC, 8'h00, "en0_sec_frozen");
        en = 1'b1;
        want(F_TICK, 8'd0, "en1_presc_held");
        step(1);
        want(F_TICK, 8'd1, "en1_tick");
        step(1);
        want(F_SEC, 8'h01, "en1_sec");

        step(132);
        want(F_SEC, 8'h34, "sec_34");
        btn_mode = 1'b1; step(1); btn_mode = 1'b0;
        btn_inc = 1'b1; step(12); btn_inc = 1'b0;
        want(F_MIN, 8'h12, "min_12");
        want(F_SEC, 8'h34, "sec_34_held");
        want(F_MODE, 8'd1, "mode_set_min_d");
        for (int t = 0; t < 4; t++) begin
            want(F_MBL, {7'd0, blink_exp((1 + t) % 4)}, $sformatf("min_blank_p%0d", (1 + t) % 4));
            want(F_HBL, 8'd0, "hr_blank_in_set_min");
            step(1);
        end

        #2;
        rst = 1'b1;
        want(F_SEC, 8'h00, "async_rst_sec");
        want(F_MIN, 8'h00, "async_rst_min");
        want(F_MODE, 8'd0, "async_rst_mode");
        want(F_MBL, 8'd0, "async_rst_blank");
        step(1);
        rst = 1'b0;
        step(2);

        while (sb.size() > 0) begin
            left = sb.pop_front();
            compared++;
            mismatched++;
            $display("FAIL %s: never checked, required %h", left.name, left.v);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
